alu_bist: RTL and testbench

Synthesizable built-in self-test initiator for the MIPS CPU's 32-bit ALU. It drives `srca`/`srcb`/`alucontrol` into the ALU and sweeps all eight opcodes for each operand pair. It compares `result`/`zero` against an internal golden model and reports pass/fail plus the first failing point. It sits beside the ALU in the datapath test wrapper and is the stimulus/check side of the ALU interface.

---
 rtl/alu_bist.sv | 144 ++++++++++++++
 tb/tb_alu_bist.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_bist.sv
//==============================================================================
// Module   : alu_bist
// Purpose  : Built-in self-test initiator for the 32-bit MIPS ALU. Sweeps all
//            eight opcodes per operand pair and checks result/zero.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module alu_bist #(
    parameter logic [31:0] SEED      = 32'h00083191,
    parameter int          N_VECTORS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] srca,
    output logic [31:0] srcb,
    output logic [2:0]  alucontrol,
    input  logic [31:0] result,
    input  logic        zero,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] first_err_vec,
    output logic [2:0]  first_err_op
);

    localparam logic [31:0] c_seed_init = (SEED == 32'h0) ? 32'h00000001 : SEED;
    localparam logic [31:0] c_lfsr_taps = 32'h80200003;
    localparam logic [15:0] c_last_vec  = 16'(N_VECTORS - 1);
    localparam logic [2:0]  c_op_slt    = 3'b111;
    localparam logic [2:0]  c_op_unused = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_lfsr;
    logic [15:0] r_vec;

    logic [31:0] w_expected;
    logic        w_mismatch;
    logic [15:0] w_err_next;
    logic [31:0] w_lfsr_a;
    logic [31:0] w_lfsr_b;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? c_lfsr_taps : 32'h0);
    endfunction

    always_comb begin
        w_expected = '0;
        case (alucontrol)
            3'b000:  w_expected = srca & srcb;
            3'b001:  w_expected = srca | srcb;
            3'b010:  w_expected = srca + srcb;
            3'b100:  w_expected = srca & ~srcb;
            3'b101:  w_expected = srca | ~srcb;
            3'b110:  w_expected = srca - srcb;
            3'b111:  w_expected = {31'b0, $signed(srca) < $signed(srcb)};
            default: w_expected = '0;
        endcase
    end

    // Opcode 011 has no defined ALU behaviour, so it never counts as an error.
    assign w_mismatch = (alucontrol != c_op_unused) &&
                        ((result != w_expected) || (zero != (w_expected == 32'h0)));
    assign w_err_next = (w_mismatch && (err_count != 16'hFFFF)) ? err_count + 16'd1
                                                                 : err_count;
    assign w_lfsr_a   = lfsr_step(r_lfsr);
    assign w_lfsr_b   = lfsr_step(w_lfsr_a);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_lfsr        <= c_seed_init;
            r_vec         <= '0;
            srca          <= '0;
            srcb          <= '0;
            alucontrol    <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_op  <= '0;
            first_err_vec <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state       <= ST_RUN;
                        r_lfsr        <= c_seed_init;
                        r_vec         <= '0;
                        srca          <= '0;
                        srcb          <= '0;
                        alucontrol    <= '0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        err_count     <= '0;
                        first_err_op  <= '0;
                        first_err_vec <= '0;
                    end
                end
                ST_RUN: begin
                    err_count <= w_err_next;
                    if (w_mismatch && (err_count == 16'h0)) begin
                        first_err_op  <= alucontrol;
                        first_err_vec <= r_vec;
                    end
                    if (alucontrol != c_op_slt) begin
                        alucontrol <= alucontrol + 3'd1;
                    end else if (r_vec != c_last_vec) begin
                        alucontrol <= '0;
                        r_vec      <= r_vec + 16'd1;
                        // Vector 1 is a fixed signed-overflow corner; the LFSR only feeds vec>=2.
                        if (r_vec == 16'h0) begin
                            srca <= 32'h7FFFFFFF;
                            srcb <= 32'h80000000;
                        end else begin
                            srca   <= w_lfsr_a;
                            srcb   <= w_lfsr_b;
                            r_lfsr <= w_lfsr_b;
                        end
                    end else begin
                        r_state <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (w_err_next == 16'h0);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_bist.sv
//==============================================================================
// Module   : tb_alu_bist
// Purpose  : Randomized self-checking bench for alu_bist with injectable ALU faults.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_alu_bist;

    localparam logic [31:0] SEED_A = 32'h00083191;
    localparam int          N_A    = 4;
    localparam int          N_B    = 2;
    localparam int          N_C    = 9370;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_ab, reset_c, start_a, start_b, start_c;
    logic [31:0] srca_a, srcb_a, result_a, srca_b, srcb_b, result_b, srca_c, srcb_c, result_c;
    logic [2:0]  alu_a, alu_b, alu_c, fop_a, fop_b, fop_c;
    logic        zero_a, zero_b, zero_c;
    logic        busy_a, busy_b, busy_c, done_a, done_b, done_c, pass_a, pass_b, pass_c;
    logic [15:0] err_a, err_b, err_c, fvec_a, fvec_b, fvec_c;

    int          mode_a, mode_b;
    logic [2:0]  inj_op;
    logic [31:0] inj_mask;
    logic [31:0] obs_a [N_A];
    logic [31:0] obs_b [N_A];
    int          total = 0;
    int          bad   = 0;

    alu_bist #(.SEED(SEED_A), .N_VECTORS(N_A)) dut_a (
        .clk(clk), .reset(reset_ab), .start(start_a), .srca(srca_a), .srcb(srcb_a),
        .alucontrol(alu_a), .result(result_a), .zero(zero_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_count(err_a), .first_err_vec(fvec_a), .first_err_op(fop_a));

    alu_bist #(.SEED(32'h0), .N_VECTORS(N_B)) dut_b (
        .clk(clk), .reset(reset_ab), .start(start_b), .srca(srca_b), .srcb(srcb_b),
        .alucontrol(alu_b), .result(result_b), .zero(zero_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_count(err_b), .first_err_vec(fvec_b), .first_err_op(fop_b));

    alu_bist #(.SEED(SEED_A), .N_VECTORS(N_C)) dut_c (
        .clk(clk), .reset(reset_c), .start(start_c), .srca(srca_c), .srcb(srcb_c),
        .alucontrol(alu_c), .result(result_c), .zero(zero_c), .busy(busy_c), .done(done_c),
        .pass(pass_c), .err_count(err_c), .first_err_vec(fvec_c), .first_err_op(fop_c));

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
    endfunction

    function automatic logic [31:0] golden(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd4:    return a & ~b;
            3'd5:    return a | ~b;
            3'd6:    return a - b;
            3'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // External ALU: mode 0 good, 1 add+1, 2 zero stuck 0, 3 unsigned slt,
    // 4 every result inverted, 5 xor mask on one opcode.
    function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] op, input int mode,
                                              input logic [2:0] fop, input logic [31:0] fmask);
        logic [31:0] r;
        logic        z;
        r = (op == 3'd3) ? (a ^ b) : golden(a, b, op);
        if (mode == 1 && op == 3'd2) r = a + b + 32'd1;
        if (mode == 3 && op == 3'd7) r = (a < b) ? 32'd1 : 32'd0;
        if (mode == 4) r = ~r;
        if (mode == 5 && op == fop) r = r ^ fmask;
        z = (r == 32'd0);
        if (mode == 2) z = 1'b0;
        return {z, r};
    endfunction

    always_comb {zero_a, result_a} = alu_model(srca_a, srcb_a, alu_a, mode_a, inj_op, inj_mask);
    always_comb {zero_b, result_b} = alu_model(srca_b, srcb_b, alu_b, mode_b, 3'd0, 32'd0);
    always_comb {zero_c, result_c} = alu_model(srca_c, srcb_c, alu_c, 4, 3'd0, 32'd0);

    // Whole-run reference: walks the operand list and opcodes, counting disagreements.
    task automatic model_run(input int n, input logic [31:0] seed, input int mode,
                             input logic [2:0] fop, input logic [31:0] fmask,
                             output int cnt, output logic [2:0] e_op, output logic [15:0] e_vec);
        logic [31:0] s, a, b, exp_r;
        s = (seed == 32'h0) ? 32'h1 : seed;
        cnt = 0; e_op = 3'd0; e_vec = 16'd0;
        for (int v = 0; v < n; v++) begin
            if (v == 0) begin
                a = 32'h0; b = 32'h0;
            end else if (v == 1) begin
                a = 32'h7FFFFFFF; b = 32'h80000000;
            end else begin
                s = lfsr_next(s); a = s;
                s = lfsr_next(s); b = s;
            end
            for (int op = 0; op < 8; op++) begin
                if (op != 3) begin
                    exp_r = golden(a, b, 3'(op));
                    if (alu_model(a, b, 3'(op), mode, fop, fmask) !== {exp_r == 32'h0, exp_r}) begin
                        if (cnt == 0) begin
                            e_op = 3'(op); e_vec = 16'(v);
                        end
                        cnt++;
                    end
                end
            end
        end
        if (cnt > 65535) cnt = 65535;
    endtask

    function automatic logic [63:0] model_vec(input int v, input logic [31:0] seed);
        logic [31:0] s, a, b;
        s = (seed == 32'h0) ? 32'h1 : seed;
        if (v == 0) return 64'h0;
        if (v == 1) return {32'h7FFFFFFF, 32'h80000000};
        a = 32'h0; b = 32'h0;
        for (int k = 2; k <= v; k++) begin
            s = lfsr_next(s); a = s;
            s = lfsr_next(s); b = s;
        end
        return {a, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start on dut_a (which=0) or dut_b (which=1) and waits for done.
    task automatic run_dut(input int which, output int cycles);
        if (which == 0) start_a = 1'b1; else start_b = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        cycles = 0;
        if (which == 0) begin obs_a[0] = srca_a; obs_b[0] = srcb_a; end
        while (((which == 0) ? !done_a : !done_b) && cycles < 8 * N_A + 10) begin
            tick();
            cycles++;
            if (which == 0 && cycles % 8 == 0 && cycles / 8 < N_A) begin
                obs_a[cycles / 8] = srca_a;
                obs_b[cycles / 8] = srcb_a;
            end
        end
    endtask

    task automatic test_reset();
        reset_ab = 1'b0; reset_c = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        mode_a = 0; mode_b = 0; inj_op = 3'd0; inj_mask = 32'd0;
        repeat (3) tick();
        total++;
        if ({srca_a, srcb_a, alu_a} !== 67'h0) begin
            bad++; $display("FAIL reset_stimulus: got %0h expected 0", {srca_a, srcb_a, alu_a});
        end
        total++;
        if ({busy_a, done_a, pass_a, err_a, fop_a, fvec_a} !== 38'h0) begin
            bad++;
            $display("FAIL reset_status: got %0h expected 0", {busy_a, done_a, pass_a, err_a, fop_a, fvec_a});
        end
        reset_ab = 1'b1; reset_c = 1'b1;
        repeat ($urandom_range(1, 3)) tick();
        total++;
        if ({busy_a, done_a, busy_b, done_b} !== 4'b0) begin
            bad++; $display("FAIL idle_after_reset: got %0b expected 0000", {busy_a, done_a, busy_b, done_b});
        end
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
    endtask

    task automatic test_golden();
        int cyc;
        repeat ($urandom_range(0, 5)) tick();
        mode_a = 0;
        run_dut(0, cyc);
        total++;
        if (cyc !== 8 * N_A) begin
            bad++; $display("FAIL golden_latency: got %0d cycles expected %0d", cyc, 8 * N_A);
        end
        total++;
        if ({busy_a, done_a, pass_a, err_a} !== {1'b0, 1'b1, 1'b1, 16'h0}) begin
            bad++;
            $display("FAIL golden_result: busy=%0b done=%0b pass=%0b err=%0d expected 0 1 1 0",
                     busy_a, done_a, pass_a, err_a);
        end
        for (int v = 0; v < N_A; v++) begin
            total++;
            if ({obs_a[v], obs_b[v]} !== model_vec(v, SEED_A)) begin
                bad++;
                $display("FAIL golden_vec%0d: got %h expected %h", v, {obs_a[v], obs_b[v]}, model_vec(v, SEED_A));
            end
        end
    endtask

    task automatic test_plan_faults();
        int cyc;
        mode_a = 1;
        run_dut(0, cyc);
        total++;
        if ({err_a, fop_a, fvec_a, pass_a, done_a} !== {16'd4, 3'b010, 16'd0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL add_plus1: err=%0d op=%0d vec=%0d pass=%0b done=%0b expected 4 2 0 0 1",
                     err_a, fop_a, fvec_a, pass_a, done_a);
        end
        mode_b = 2;
        run_dut(1, cyc);
        total++;
        if ({err_b, fop_b, fvec_b, pass_b, done_b} !== {16'd8, 3'b000, 16'd0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL zero_stuck: err=%0d op=%0d vec=%0d pass=%0b done=%0b expected 8 0 0 0 1",
                     err_b, fop_b, fvec_b, pass_b, done_b);
        end
        mode_b = 3;
        run_dut(1, cyc);
        total++;
        if ({err_b, fop_b, fvec_b, pass_b} !== {16'd1, 3'b111, 16'd1, 1'b0}) begin
            bad++;
            $display("FAIL unsigned_slt: err=%0d op=%0d vec=%0d pass=%0b expected 1 7 1 0",
                     err_b, fop_b, fvec_b, pass_b);
        end
    endtask

    task automatic test_random_faults();
        int          cyc, cnt;
        logic [2:0]  e_op;
        logic [15:0] e_vec;
        for (int it = 0; it < 8; it++) begin
            mode_a   = (it % 2 == 0) ? 5 : int'($urandom_range(0, 3));
            inj_op   = 3'($urandom_range(0, 7));
            inj_mask = $urandom;
            if (inj_mask == 32'h0) inj_mask = 32'h1;
            repeat ($urandom_range(0, 3)) tick();
            run_dut(0, cyc);
            model_run(N_A, SEED_A, mode_a, inj_op, inj_mask, cnt, e_op, e_vec);
            total++;
            if ({err_a, pass_a} !== {16'(cnt), cnt == 0}) begin
                bad++;
                $display("FAIL random_count%0d: err=%0d pass=%0b expected %0d %0b (mode %0d op %0d)",
                         it, err_a, pass_a, cnt, cnt == 0, mode_a, inj_op);
            end
            if (cnt > 0) begin
                total++;
                if ({fop_a, fvec_a} !== {e_op, e_vec}) begin
                    bad++;
                    $display("FAIL random_first%0d: op=%0d vec=%0d expected %0d %0d",
                             it, fop_a, fvec_a, e_op, e_vec);
                end
            end
        end
        mode_a = 0;
    endtask

    task automatic test_reset_midrun();
        int cyc;
        mode_a = 2;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (10) tick();
        reset_ab = 1'b0;
        tick();
        reset_ab = 1'b1;
        total++;
        if ({srca_a, srcb_a, alu_a, busy_a, done_a, pass_a, err_a, fop_a, fvec_a} !== 105'h0) begin
            bad++;
            $display("FAIL midrun_reset: srca=%h srcb=%h op=%0d busy=%0b done=%0b err=%0d expected all 0",
                     srca_a, srcb_a, alu_a, busy_a, done_a, err_a);
        end
        mode_a = 0;
        run_dut(0, cyc);
        total++;
        if ({cyc, pass_a, err_a} !== {8 * N_A, 1'b1, 16'h0}) begin
            bad++; $display("FAIL rerun_result: cycles=%0d pass=%0b err=%0d expected %0d 1 0", cyc, pass_a, err_a, 8 * N_A);
        end
        for (int v = 0; v < N_A; v++) begin
            total++;
            if ({obs_a[v], obs_b[v]} !== model_vec(v, SEED_A)) begin
                bad++;
                $display("FAIL rerun_vec%0d: got %h expected %h", v, {obs_a[v], obs_b[v]}, model_vec(v, SEED_A));
            end
        end
    endtask

    task automatic test_start_held();
        int cyc;
        mode_a = 1;
        start_a = 1'b1;
        tick();
        cyc = 0;
        while (!done_a && cyc < 8 * N_A + 10) begin
            tick();
            cyc++;
        end
        total++;
        if ({cyc, err_a} !== {8 * N_A, 16'd4}) begin
            bad++; $display("FAIL held_start_run: cycles=%0d err=%0d expected %0d 4", cyc, err_a, 8 * N_A);
        end
        tick();
        total++;
        if ({busy_a, done_a, err_a, fop_a, fvec_a} !== {1'b1, 1'b0, 16'h0, 3'h0, 16'h0}) begin
            bad++;
            $display("FAIL held_start_restart: busy=%0b done=%0b err=%0d op=%0d vec=%0d expected 1 0 0 0 0",
                     busy_a, done_a, err_a, fop_a, fvec_a);
        end
        start_a = 1'b0;
        cyc = 0;
        while (!done_a && cyc < 8 * N_A + 10) begin
            tick();
            cyc++;
        end
        total++;
        if ({cyc, err_a, pass_a} !== {8 * N_A, 16'd4, 1'b0}) begin
            bad++; $display("FAIL held_start_second: cycles=%0d err=%0d pass=%0b expected %0d 4 0", cyc, err_a, pass_a, 8 * N_A);
        end
        mode_a = 0;
    endtask

    task automatic test_saturation();
        int          waited, cnt;
        logic [2:0]  e_op;
        logic [15:0] e_vec;
        waited = 0;
        while (!done_c && waited < 80000) begin
            tick();
            waited++;
        end
        total++;
        if (done_c !== 1'b1) begin
            bad++; $display("FAIL saturation_timeout: done=%0b expected 1", done_c);
        end
        model_run(N_C, SEED_A, 4, 3'd0, 32'd0, cnt, e_op, e_vec);
        total++;
        if ({err_c, pass_c, fop_c, fvec_c} !== {16'(cnt), 1'b0, e_op, e_vec}) begin
            bad++;
            $display("FAIL saturation: err=%h pass=%0b op=%0d vec=%0d expected %h 0 %0d %0d",
                     err_c, pass_c, fop_c, fvec_c, 16'(cnt), e_op, e_vec);
        end
    endtask

    initial begin
        test_reset();
        test_golden();
        test_plan_faults();
        test_random_faults();
        test_reset_midrun();
        test_start_held();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
